// File: rtl/booth_mac_pkg.sv
// Shared definitions for the Booth-product MAC accumulator.
//   PROD_W_DEF / ACC_W_DEF : default product and accumulator widths
//   mac_state_e            : result-slot state (ACCUM = empty, HOLD = full)
//   ACC_MAX / ACC_MIN      : signed clamp limits for the default ACC_W
package booth_mac_pkg;

    localparam int unsigned PROD_W_DEF = 16;
    localparam int unsigned ACC_W_DEF  = 24;

    // State value doubles as res_valid.
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } mac_state_e;

    localparam logic [ACC_W_DEF-1:0] ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
    localparam logic [ACC_W_DEF-1:0] ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

endpackage : booth_mac_pkg

// File: rtl/sat_add.sv
// Combinational signed adder with optional saturation.
//   a_i        : signed accumulator operand
//   b_i        : signed addend, already sign-extended to ACC_W
//   saturate_i : 1 = clamp on overflow, 0 = two's-complement wrap
//   sum_o      : clamped or wrapped sum
//   ovf_o      : signed overflow of the raw addition
module sat_add
    import booth_mac_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0] a_i,
    input  logic [ACC_W-1:0] b_i,
    input  logic             saturate_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             ovf_o
);

    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W-1:0] raw_sum;

    assign raw_sum = a_i + b_i;

    // Overflow: both operands share a sign the raw sum does not.
    always_comb begin
        ovf_o = (a_i[ACC_W-1] == b_i[ACC_W-1]) && (raw_sum[ACC_W-1] != a_i[ACC_W-1]);
        sum_o = raw_sum;
        if (ovf_o && saturate_i) begin
            sum_o = a_i[ACC_W-1] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule : sat_add

// File: rtl/booth_mac_accumulator.sv
// Accumulates NUM_TERMS signed multiplier products into one dot-product
// result held in a single output slot with valid/ready backpressure.
//   clk, rst    : clock, asynchronous active-high reset
//   prod        : signed product input; prod_valid / prod_ready handshake
//   prod_ready  : combinational accept indication
//   clear       : synchronous abort of the group in progress
//   res         : registered group result; res_ovf sticky overflow of group
//   res_valid   : result slot full; res_ready consumes it
//   term_cnt    : products accepted so far in the current group
module booth_mac_accumulator
    import booth_mac_pkg::*;
#(
    parameter int unsigned PROD_W    = PROD_W_DEF,
    parameter int unsigned ACC_W     = ACC_W_DEF,
    parameter int unsigned NUM_TERMS = 8,
    parameter bit          SATURATE  = 1'b1,
    localparam int unsigned CNT_W    = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PROD_W-1:0] prod,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic              clear,
    output logic [ACC_W-1:0]  res,
    output logic              res_ovf,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CNT_W-1:0]  term_cnt
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_TERMS - 1);

    mac_state_e       state_q;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] term_cnt_q, term_cnt_d;
    logic             ovf_sticky_q, ovf_sticky_d;
    logic [ACC_W-1:0] res_q;
    logic             res_ovf_q;

    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] sum;
    logic             ovf;
    logic             accept;
    logic             take_last;

    assign prod_ready = !clear && ((state_q == ACCUM) || res_ready);
    assign accept     = prod_valid && prod_ready;
    assign take_last  = accept && (term_cnt_q == LAST_IDX);

    assign prod_ext = ACC_W'($signed(prod));

    sat_add #(
        .ACC_W (ACC_W)
    ) u_sat_add (
        .a_i        (acc_q),
        .b_i        (prod_ext),
        .saturate_i (SATURATE),
        .sum_o      (sum),
        .ovf_o      (ovf)
    );

    // Group accumulator next state: clear wins, last term restarts the group.
    always_comb begin
        acc_d        = acc_q;
        term_cnt_d   = term_cnt_q;
        ovf_sticky_d = ovf_sticky_q;
        if (clear || take_last) begin
            acc_d        = '0;
            term_cnt_d   = '0;
            ovf_sticky_d = 1'b0;
        end else if (accept) begin
            acc_d        = sum;
            term_cnt_d   = term_cnt_q + CNT_W'(1);
            ovf_sticky_d = ovf_sticky_q | ovf;
        end
    end

    // Registers and result-slot FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ACCUM;
            acc_q        <= '0;
            term_cnt_q   <= '0;
            ovf_sticky_q <= 1'b0;
            res_q        <= '0;
            res_ovf_q    <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            term_cnt_q   <= term_cnt_d;
            ovf_sticky_q <= ovf_sticky_d;
            if (take_last) begin
                res_q     <= sum;
                res_ovf_q <= ovf_sticky_q | ovf;
            end
            case (state_q)
                ACCUM: begin
                    if (take_last) begin
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    // A last term landing with the handshake refills the slot.
                    if (res_ready && !take_last) begin
                        state_q <= ACCUM;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign res       = res_q;
    assign res_ovf   = res_ovf_q;
    assign res_valid = (state_q == HOLD);
    assign term_cnt  = term_cnt_q;

endmodule : booth_mac_accumulator

// File: tb/tb_booth_mac_accumulator.sv
module tb_booth_mac_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] prod;
    logic        prod_valid;
    logic        clear;
    logic        res_ready;

    // Four variants on shared inputs: 24b sat, 16b sat, 16b wrap, 24b single-term.
    logic        pr_a, pr_s, pr_w, pr_o;
    logic [23:0] res_a, res_o;
    logic [15:0] res_s, res_w;
    logic        ovf_a, ovf_s, ovf_w, ovf_o;
    logic        v_a, v_s, v_w, v_o;
    logic [1:0]  cnt_a, cnt_s, cnt_w;
    logic [0:0]  cnt_o;

    always #5 clk = ~clk;

    booth_mac_accumulator #(.PROD_W(16), .ACC_W(24), .NUM_TERMS(4), .SATURATE(1'b1)) u_a (
        .clk(clk), .rst(rst), .prod(prod), .prod_valid(prod_valid), .prod_ready(pr_a),
        .clear(clear), .res(res_a), .res_ovf(ovf_a), .res_valid(v_a), .res_ready(res_ready),
        .term_cnt(cnt_a));
    booth_mac_accumulator #(.PROD_W(16), .ACC_W(16), .NUM_TERMS(4), .SATURATE(1'b1)) u_s (
        .clk(clk), .rst(rst), .prod(prod), .prod_valid(prod_valid), .prod_ready(pr_s),
        .clear(clear), .res(res_s), .res_ovf(ovf_s), .res_valid(v_s), .res_ready(res_ready),
        .term_cnt(cnt_s));
    booth_mac_accumulator #(.PROD_W(16), .ACC_W(16), .NUM_TERMS(4), .SATURATE(1'b0)) u_w (
        .clk(clk), .rst(rst), .prod(prod), .prod_valid(prod_valid), .prod_ready(pr_w),
        .clear(clear), .res(res_w), .res_ovf(ovf_w), .res_valid(v_w), .res_ready(res_ready),
        .term_cnt(cnt_w));
    booth_mac_accumulator #(.PROD_W(16), .ACC_W(24), .NUM_TERMS(1), .SATURATE(1'b1)) u_o (
        .clk(clk), .rst(rst), .prod(prod), .prod_valid(prod_valid), .prod_ready(pr_o),
        .clear(clear), .res(res_o), .res_ovf(ovf_o), .res_valid(v_o), .res_ready(res_ready),
        .term_cnt(cnt_o));

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: plain integer arithmetic per variant.
    int     mw  [4] = '{24, 16, 16, 24};
    bit     msat[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    int     mnt [4] = '{4, 4, 4, 1};
    longint m_acc [4];
    longint m_res [4];
    bit     m_stk [4];
    bit     m_rovf[4];
    bit     m_v   [4];
    int     m_cnt [4];

    function automatic longint dut_res(input int i);
        case (i)
            0:       return longint'($signed(res_a));
            1:       return longint'($signed(res_s));
            2:       return longint'($signed(res_w));
            default: return longint'($signed(res_o));
        endcase
    endfunction

    function automatic longint dut_bit(input int i, input int which);
        logic b;
        case (which)
            0:       b = (i == 0) ? pr_a  : (i == 1) ? pr_s  : (i == 2) ? pr_w  : pr_o;
            1:       b = (i == 0) ? v_a   : (i == 1) ? v_s   : (i == 2) ? v_w   : v_o;
            default: b = (i == 0) ? ovf_a : (i == 1) ? ovf_s : (i == 2) ? ovf_w : ovf_o;
        endcase
        return longint'(b);
    endfunction

    function automatic longint dut_cnt(input int i);
        case (i)
            0:       return longint'(cnt_a);
            1:       return longint'(cnt_s);
            2:       return longint'(cnt_w);
            default: return longint'(cnt_o);
        endcase
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_add(input int i, input longint a, input longint b,
                                      output longint s, output bit o);
        longint mx, mn;
        mx = (longint'(1) <<< (mw[i] - 1)) - 1;
        mn = -mx - 1;
        s  = a + b;
        o  = 1'b0;
        if (s > mx) begin
            o = 1'b1;
            s = msat[i] ? mx : s - 2 * (mx + 1);
        end else if (s < mn) begin
            o = 1'b1;
            s = msat[i] ? mn : s + 2 * (mx + 1);
        end
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_acc[i] = 0; m_res[i] = 0; m_stk[i] = 1'b0;
            m_rovf[i] = 1'b0; m_v[i] = 1'b0; m_cnt[i] = 0;
        end
    endtask

    // One clock: drive, compare every output with the model, then advance the model.
    task automatic cycle(input bit pv, input logic [15:0] p, input bit clr, input bit rr,
                         output bit accepted0);
        bit     rdy[4];
        bit     acc_ok[4];
        longint s;
        bit     o;
        @(negedge clk);
        prod_valid = pv; prod = p; clear = clr; res_ready = rr;
        #1;
        for (int i = 0; i < 4; i++) begin
            rdy[i]    = !clr && (!m_v[i] || rr);
            acc_ok[i] = pv && rdy[i];
            chk($sformatf("prod_ready[%0d]", i), dut_bit(i, 0), longint'(rdy[i]));
            chk($sformatf("res_valid[%0d]", i),  dut_bit(i, 1), longint'(m_v[i]));
            chk($sformatf("res[%0d]", i),        dut_res(i),    m_res[i]);
            chk($sformatf("res_ovf[%0d]", i),    dut_bit(i, 2), longint'(m_rovf[i]));
            chk($sformatf("term_cnt[%0d]", i),   dut_cnt(i),    longint'(m_cnt[i]));
        end
        accepted0 = acc_ok[0];
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            if (m_v[i] && rr) m_v[i] = 1'b0;
            if (clr) begin
                m_acc[i] = 0; m_cnt[i] = 0; m_stk[i] = 1'b0;
            end else if (acc_ok[i]) begin
                model_add(i, m_acc[i], longint'($signed(p)), s, o);
                if (m_cnt[i] == mnt[i] - 1) begin
                    m_res[i] = s; m_rovf[i] = m_stk[i] | o; m_v[i] = 1'b1;
                    m_acc[i] = 0; m_cnt[i] = 0; m_stk[i] = 1'b0;
                end else begin
                    m_acc[i] = s; m_cnt[i]++; m_stk[i] = m_stk[i] | o;
                end
            end
        end
        #1;
    endtask

    task automatic grp(input int v0, input int v1, input int v2, input int v3, input bit rr);
        int v[4];
        bit a;
        v = '{v0, v1, v2, v3};
        for (int k = 0; k < 4; k++) cycle(1'b1, 16'(v[k]), 1'b0, rr, a);
    endtask

    // Reset asserted between edges must take effect without a clock.
    task automatic async_reset(input string tag);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_valid"}, dut_bit(i, 1), 0);
            chk({tag, "_res"},   dut_res(i),    0);
            chk({tag, "_cnt"},   dut_cnt(i),    0);
        end
        model_reset();
        prod_valid = 1'b0; clear = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit          a;
        bit          pv_hold;
        bit          d_pv, d_rr, d_clr;
        logic [15:0] d_p;

        rst = 1'b1; prod = '0; prod_valid = 1'b0; clear = 1'b0; res_ready = 1'b0;
        model_reset();
        #12;
        for (int i = 0; i < 4; i++) begin
            chk("reset_valid", dut_bit(i, 1), 0);
            chk("reset_res",   dut_res(i),    0);
            chk("reset_cnt",   dut_cnt(i),    0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Basic group, back-to-back.
        grp(100, -50, 25, 7, 1'b1);
        chk("t1_res", dut_res(0), 82);
        chk("t1_ovf", dut_bit(0, 2), 0);
        chk("t1_valid", dut_bit(0, 1), 1);

        // Overflow: saturate vs wrap on 16-bit accumulators.
        grp(32767, 32767, -1, 0, 1'b1);
        chk("t3_sat_res", dut_res(1), 32766);
        chk("t3_sat_ovf", dut_bit(1, 2), 1);
        chk("t3_wrap_res", dut_res(2), -3);
        chk("t3_wrap_ovf", dut_bit(2, 2), 1);
        chk("t3_wide_res", dut_res(0), 65533);
        grp(1, 1, 1, 1, 1'b1);
        chk("t3_next_res", dut_res(1), 4);
        chk("t3_next_ovf", dut_bit(1, 2), 0);

        // Backpressure: result held, input stalled, then released.
        grp(1, 1, 1, 1, 1'b0);
        chk("t2_res", dut_res(0), 4);
        for (int k = 0; k < 3; k++) cycle(1'b1, 16'd5, 1'b0, 1'b0, a);
        chk("t2_stall_ready", longint'(pr_a), 0);
        grp(5, 5, 5, 5, 1'b1);
        chk("t2_res2", dut_res(0), 20);

        // Clear mid-group; product offered during clear is dropped.
        cycle(1'b1, 16'd500, 1'b0, 1'b1, a);
        cycle(1'b1, 16'd600, 1'b0, 1'b1, a);
        cycle(1'b1, 16'd999, 1'b1, 1'b1, a);
        grp(1, 2, 3, 4, 1'b1);
        chk("t4_res", dut_res(0), 10);
        chk("t4_ovf", dut_bit(0, 2), 0);

        // Extremes on the wide accumulator.
        grp(16384, 16384, 16384, 16384, 1'b1);
        chk("t5_pos", dut_res(0), 65536);
        grp(-16256, -16256, -16256, -16256, 1'b1);
        chk("t5_neg", dut_res(0), -65024);

        // Async reset mid-group and in HOLD.
        cycle(1'b1, 16'd77, 1'b0, 1'b1, a);
        cycle(1'b1, 16'd88, 1'b0, 1'b1, a);
        async_reset("rst_mid");
        grp(9, 9, 9, 9, 1'b0);
        async_reset("rst_hold");
        grp(1, 2, 3, 4, 1'b1);
        chk("t6_res", dut_res(0), 10);

        // Randomized traffic; input is held while stalled.
        pv_hold = 1'b0; d_pv = 1'b0; d_p = '0;
        for (int n = 0; n < 1500; n++) begin
            if (!pv_hold) begin
                d_pv = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 3))
                    0:       d_p = 16'h7FFF;
                    1:       d_p = 16'h8000;
                    2:       d_p = 16'($urandom_range(0, 255)) - 16'd128;
                    default: d_p = 16'($urandom);
                endcase
            end
            d_rr  = ($urandom_range(0, 9) < 7);
            d_clr = ($urandom_range(0, 24) == 0);
            cycle(d_pv, d_p, d_clr, d_rr, a);
            pv_hold = d_pv && !a;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_booth_mac_accumulator
